// File: rtl/e_stage_operand_reg.sv
// D->E pipeline register for the 5-stage MIPS core with the E-stage operand
// forwarding muxes for rs/rt, bubble insertion on stall and a bubble counter.
module e_stage_operand_reg #(
  parameter int          W     = 32,
  parameter logic [31:0] NOP   = 32'h0,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             freeze,
  input  logic             stall,
  input  logic [31:0]      instrD,
  input  logic [W-1:0]     pc8D,
  input  logic [W-1:0]     rs_dataD,
  input  logic [W-1:0]     rt_dataD,
  input  logic [W-1:0]     extimmD,
  input  logic             alu_srcE,
  input  logic [1:0]       bypass_rs_alu,
  input  logic [1:0]       bypass_rt_alu,
  input  logic [W-1:0]     resultM,
  input  logic [W-1:0]     resultW,
  output logic [31:0]      instrE,
  output logic             validE,
  output logic [W-1:0]     pc8E,
  output logic [W-1:0]     extimmE,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [W-1:0]     store_dataE,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0]      r_instr;
  logic             r_valid;
  logic [W-1:0]     r_pc8;
  logic [W-1:0]     r_rs;
  logic [W-1:0]     r_rt;
  logic [W-1:0]     r_imm;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [W-1:0]     w_fwd_rs;
  logic [W-1:0]     w_fwd_rt;

  // Freeze outranks stall so a bubble is never counted while E is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr      <= NOP;
      r_valid      <= 1'b0;
      r_pc8        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_imm        <= '0;
      r_bubble_cnt <= '0;
    end else if (!freeze) begin
      if (stall) begin
        r_instr <= NOP;
        r_valid <= 1'b0;
        r_pc8   <= '0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_imm   <= '0;
        if (r_bubble_cnt != {CNT_W{1'b1}})
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end else begin
        r_instr <= instrD;
        r_valid <= 1'b1;
        r_pc8   <= pc8D;
        r_rs    <= rs_dataD;
        r_rt    <= rt_dataD;
        r_imm   <= extimmD;
      end
    end
  end

  // Select 3 is reserved and falls back to the latched operand.
  always_comb begin
    w_fwd_rs = r_rs;
    w_fwd_rt = r_rt;
    case (bypass_rs_alu)
      2'd1:    w_fwd_rs = resultM;
      2'd2:    w_fwd_rs = resultW;
      default: w_fwd_rs = r_rs;
    endcase
    case (bypass_rt_alu)
      2'd1:    w_fwd_rt = resultM;
      2'd2:    w_fwd_rt = resultW;
      default: w_fwd_rt = r_rt;
    endcase
  end

  assign instrE      = r_instr;
  assign validE      = r_valid;
  assign pc8E        = r_pc8;
  assign extimmE     = r_imm;
  assign alu_a       = w_fwd_rs;
  assign alu_b       = alu_srcE ? r_imm : w_fwd_rt;
  assign store_dataE = w_fwd_rt;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_e_stage_operand_reg.sv
// Bench for e_stage_operand_reg: directed scenarios plus random traffic
// compared against a transaction-level model of the E stage.
module tb_e_stage_operand_reg;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             freeze, stall;
  logic [31:0]      instrD;
  logic [W-1:0]     pc8D, rs_dataD, rt_dataD, extimmD;
  logic             alu_srcE;
  logic [1:0]       bypass_rs_alu, bypass_rt_alu;
  logic [W-1:0]     resultM, resultW;
  logic [31:0]      instrE;
  logic             validE;
  logic [W-1:0]     pc8E, extimmE, alu_a, alu_b, store_dataE;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mInstr;
  logic         mValid;
  logic [W-1:0] mPc8, mRs, mRt, mImm;
  int           mBubbles;

  always #5 clk = ~clk;

  e_stage_operand_reg #(.W(W), .NOP(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .stall(stall),
    .instrD(instrD), .pc8D(pc8D), .rs_dataD(rs_dataD), .rt_dataD(rt_dataD),
    .extimmD(extimmD), .alu_srcE(alu_srcE), .bypass_rs_alu(bypass_rs_alu),
    .bypass_rt_alu(bypass_rt_alu), .resultM(resultM), .resultW(resultW),
    .instrE(instrE), .validE(validE), .pc8E(pc8E), .extimmE(extimmE),
    .alu_a(alu_a), .alu_b(alu_b), .store_dataE(store_dataE),
    .bubble_cnt(bubble_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] latched);
    logic [W-1:0] src [4];
    src[0] = latched;
    src[1] = resultM;
    src[2] = resultW;
    src[3] = latched;
    return src[sel];
  endfunction

  task automatic modelReset();
    mInstr = 32'h0; mValid = 1'b0;
    mPc8 = '0; mRs = '0; mRt = '0; mImm = '0;
    mBubbles = 0;
  endtask

  task automatic checkAll();
    logic [W-1:0] fa, fb;
    fa = pick(bypass_rs_alu, mRs);
    fb = pick(bypass_rt_alu, mRt);
    checkOutput("instrE", instrE, mInstr);
    checkOutput("validE", {31'd0, validE}, {31'd0, mValid});
    checkOutput("pc8E", pc8E, mPc8);
    checkOutput("extimmE", extimmE, mImm);
    checkOutput("alu_a", alu_a, fa);
    checkOutput("alu_b", alu_b, alu_srcE ? mImm : fb);
    checkOutput("store_dataE", store_dataE, fb);
    checkOutput("bubble_cnt", {28'd0, bubble_cnt}, (mBubbles > CMAX) ? CMAX : mBubbles);
  endtask

  task automatic applyStimulus(input logic st, input logic fr, input logic [31:0] ins,
                               input logic [W-1:0] pc8, input logic [W-1:0] rs,
                               input logic [W-1:0] rt, input logic [W-1:0] imm);
    stall = st; freeze = fr;
    instrD = ins; pc8D = pc8; rs_dataD = rs; rt_dataD = rt; extimmD = imm;
    @(posedge clk);
    if (!fr) begin
      if (st) begin
        mInstr = 32'h0; mValid = 1'b0;
        mPc8 = '0; mRs = '0; mRt = '0; mImm = '0;
        mBubbles++;
      end else begin
        mInstr = ins; mValid = 1'b1;
        mPc8 = pc8; mRs = rs; mRt = rt; mImm = imm;
      end
    end
    #1;
  endtask

  task automatic setSelects(input logic src, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [W-1:0] rm, input logic [W-1:0] rw);
    alu_srcE = src; bypass_rs_alu = sa; bypass_rt_alu = sb; resultM = rm; resultW = rw;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; freeze = 1'b0; stall = 1'b0;
    instrD = '0; pc8D = '0; rs_dataD = '0; rt_dataD = '0; extimmD = '0;
    alu_srcE = 1'b0; bypass_rs_alu = 2'd0; bypass_rt_alu = 2'd0;
    resultM = '0; resultW = '0;
    modelReset();
    #12;
    checkAll();
    reset_n = 1'b1;

    // Three normal loads.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 32'h012A4020, 32'h0040_0008 + 4 * i, 32'd5, 32'd7, 32'hFFFF_FFFC);
    setSelects(1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    checkAll();
    checkOutput("t1_instrE", instrE, 32'h012A4020);
    checkOutput("t1_alu_a", alu_a, 32'd5);
    checkOutput("t1_alu_b", alu_b, 32'd7);

    // Forwarding from M and W in the same cycle.
    setSelects(1'b0, 2'd1, 2'd2, 32'hAA, 32'hBB);
    checkAll();
    checkOutput("t2_alu_a", alu_a, 32'hAA);
    checkOutput("t2_alu_b", alu_b, 32'hBB);
    checkOutput("t2_store", store_dataE, 32'hBB);

    // Immediate operand while store data is still forwarded.
    setSelects(1'b1, 2'd0, 2'd1, 32'h10, 32'hBB);
    checkAll();
    checkOutput("t3_alu_b", alu_b, 32'hFFFF_FFFC);
    checkOutput("t3_store", store_dataE, 32'h10);

    // Reserved select 3 uses the latched operands.
    setSelects(1'b0, 2'd3, 2'd3, 32'h1234, 32'h5678);
    checkOutput("sel3_alu_a", alu_a, 32'd5);
    checkOutput("sel3_store", store_dataE, 32'd7);

    // Two stalls then a load.
    setSelects(1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 32'h4);
      checkAll();
      checkOutput("t4_validE", {31'd0, validE}, 32'd0);
    end
    checkOutput("t4_cnt", {28'd0, bubble_cnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 32'h8C43_0010, 32'h0040_0020, 32'h11, 32'h22, 32'h10);
    checkAll();
    checkOutput("t4_reload", instrE, 32'h8C43_0010);

    // Freeze dominates stall.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      checkAll();
    end
    checkOutput("t5_instrE", instrE, 32'h8C43_0010);
    checkOutput("t5_cnt", {28'd0, bubble_cnt}, 32'd2);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkAll();
    checkOutput("t6_sat", {28'd0, bubble_cnt}, 32'hF);

    // Asynchronous reset pulse between edges.
    applyStimulus(1'b0, 1'b0, 32'h2001_0005, 32'h8, 32'h9, 32'hA, 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_instr", instrE, 32'h0);
    checkOutput("t6_rst_cnt", {28'd0, bubble_cnt}, 32'd0);
    checkAll();
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) == 0, ($urandom % 6) == 0, $urandom, $urandom,
                    $urandom, $urandom, $urandom);
      setSelects($urandom % 2, $urandom % 4, $urandom % 4, $urandom, $urandom);
      checkAll();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
